// File: rtl/ram_arbiter2.sv
// Two-client, block-granular arbiter in front of a single RAMController cmd/data port.
// Round-robin on ties, optional ownership lock across blocks bounded by LockLimit.
module ram_arbiter2 #(
  parameter int BlockWidth = 21,
  parameter int DataWidth  = 16,
  parameter int LockLimit  = 64
) (
  input  logic                  clk,
  input  logic                  rst_,
  // client 0
  output logic                  c0_cmd_ready,
  input  logic                  c0_cmd_trigger,
  input  logic [BlockWidth-1:0] c0_cmd_block,
  input  logic                  c0_cmd_write,
  input  logic                  c0_cmd_lock,
  output logic                  c0_data_ready,
  input  logic                  c0_data_trigger,
  input  logic [DataWidth-1:0]  c0_data_write,
  output logic [DataWidth-1:0]  c0_data_read,
  // client 1
  output logic                  c1_cmd_ready,
  input  logic                  c1_cmd_trigger,
  input  logic [BlockWidth-1:0] c1_cmd_block,
  input  logic                  c1_cmd_write,
  input  logic                  c1_cmd_lock,
  output logic                  c1_data_ready,
  input  logic                  c1_data_trigger,
  input  logic [DataWidth-1:0]  c1_data_write,
  output logic [DataWidth-1:0]  c1_data_read,
  // controller
  input  logic                  ctl_cmd_ready,
  output logic                  ctl_cmd_trigger,
  output logic [BlockWidth-1:0] ctl_cmd_block,
  output logic                  ctl_cmd_write,
  input  logic                  ctl_data_ready,
  output logic                  ctl_data_trigger,
  output logic [DataWidth-1:0]  ctl_data_write,
  input  logic [DataWidth-1:0]  ctl_data_read
);

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_e;

  state_e      state_q, state_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [15:0] lock_cnt_q, lock_cnt_d;

  logic        own_trig, own_lock, oth_trig;
  logic [16:0] cnt_inc;

  assign own_trig = owner_q ? c1_cmd_trigger : c0_cmd_trigger;
  assign own_lock = owner_q ? c1_cmd_lock    : c0_cmd_lock;
  assign oth_trig = owner_q ? c0_cmd_trigger : c1_cmd_trigger;
  assign cnt_inc  = {1'b0, lock_cnt_q} + 17'd1;

  assign c0_data_read = ctl_data_read;
  assign c1_data_read = ctl_data_read;

  always_ff @(posedge clk) begin
    if (!rst_) begin
      state_q    <= IDLE;
      owner_q    <= 1'b0;
      last_q     <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      last_q     <= last_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    last_d           = last_q;
    lock_cnt_d       = lock_cnt_q;
    c0_cmd_ready     = 1'b0;
    c1_cmd_ready     = 1'b0;
    c0_data_ready    = 1'b0;
    c1_data_ready    = 1'b0;
    ctl_cmd_trigger  = 1'b0;
    ctl_cmd_block    = '0;
    ctl_cmd_write    = 1'b0;
    ctl_data_trigger = 1'b0;
    ctl_data_write   = '0;
    unique case (state_q)
      IDLE: begin
        if (c0_cmd_trigger || c1_cmd_trigger) begin
          state_d = CMD;
          owner_d = (c0_cmd_trigger && c1_cmd_trigger) ? ~last_q : c1_cmd_trigger;
        end
      end
      CMD: begin
        ctl_cmd_trigger = own_trig;
        ctl_cmd_block   = owner_q ? c1_cmd_block : c0_cmd_block;
        ctl_cmd_write   = owner_q ? c1_cmd_write : c0_cmd_write;
        c0_cmd_ready    = !owner_q && ctl_cmd_ready;
        c1_cmd_ready    =  owner_q && ctl_cmd_ready;
        if (ctl_cmd_ready && own_trig) begin
          state_d = DATA;
        end else if (!own_trig && !own_lock) begin
          state_d    = IDLE;
          last_d     = owner_q;
          lock_cnt_d = '0;
        end
      end
      DATA: begin
        ctl_data_trigger = owner_q ? c1_data_trigger : c0_data_trigger;
        ctl_data_write   = owner_q ? c1_data_write   : c0_data_write;
        c0_data_ready    = !owner_q && ctl_data_ready;
        c1_data_ready    =  owner_q && ctl_data_ready;
        // controller raising cmd_ready again marks the end of the block
        if (ctl_cmd_ready) begin
          if (own_lock && (!oth_trig || cnt_inc < 17'(LockLimit))) begin
            state_d = CMD;
            if (lock_cnt_q < 16'(LockLimit)) lock_cnt_d = cnt_inc[15:0];
          end else begin
            state_d    = IDLE;
            last_d     = owner_q;
            lock_cnt_d = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
